ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter RD_TIMEOUT, default 255: max cycles in WAIT_RD before abort.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive video losses before video is forced to win.
REQ-003 clk50  in  1  system clock; all logic on posedge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 init_done  in  1  loader finished; readers are blocked while low.
REQ-006 ld_we / ld_address / ld_data  in  1/25/16  loader write request, address, data.
REQ-007 ld_op_begun  out  1  loader acknowledge.
REQ-008 a_req / a_address  in  1/25  audio read request and address.
REQ-009 a_op_begun / a_rdata_valid / a_rdata  out  1/1/16  audio acknowledge, read-data strobe, read data.
REQ-010 v_req / v_address, v_op_begun / v_rdata_valid / v_rdata  same widths and meanings as the audio port, for video.
REQ-011 mem_req / mem_we / mem_address / mem_wdata  out  1/1/25/16  request to the SDRAM controller.
REQ-012 mem_op_begun / mem_rdata_valid / mem_rdata  in  1/1/16  controller acknowledge, read strobe, read data.
REQ-013 owner  out  2  current grant: 0 none, 1 loader, 2 audio, 3 video.
REQ-014 rd_timeout_err  out  1  sticky; set on any read timeout.

Function
REQ-015 FSM states: IDLE, GRANT_LD, GRANT_A, GRANT_V, WAIT_RD.
REQ-016 IDLE: sample requests each cycle; winner registered; next state GRANT_x one cycle later; owner updates with the state.
REQ-017 Priority: loader (ld_we) always highest; a_req/v_req considered only when init_done=1.
REQ-018 Audio over video, except video wins when starve_cnt >= STARVE_LIMIT.
REQ-019 starve_cnt: +1 (saturating at 7) when v_req=1 but audio wins; cleared when video is granted.
REQ-020 GRANT_x: mem_req=1; mem_address/mem_we/mem_wdata muxed from the owner; mem_we=1 only in GRANT_LD; mem_wdata=0 otherwise.
REQ-021 mem_op_begun forwarded combinationally to the owner's *_op_begun only; other acks stay 0.
REQ-022 On mem_op_begun: GRANT_LD -> IDLE; GRANT_A or GRANT_V -> WAIT_RD (remembering the reader).
REQ-023 Grant is held until mem_op_begun even if the owner's request deasserts; address is re-sampled live.
REQ-024 WAIT_RD: mem_req=0; mem_rdata_valid routes mem_rdata to the owner's *_rdata with *_rdata_valid=1 in the same cycle; then -> IDLE.
REQ-025 *_rdata registered; holds the last value for that port.
REQ-026 WAIT_RD counter: counts from 0; at RD_TIMEOUT cycles without mem_rdata_valid, set rd_timeout_err and return to IDLE with no valid strobe.
REQ-027 mem_rdata_valid outside WAIT_RD is ignored.
REQ-028 Minimum turnaround: one IDLE cycle between consecutive grants.
REQ-029 init_done falling while a reader is granted: the current transaction completes; blocking applies from the next arbitration.

Reset
REQ-030 reset_n=0 asynchronously forces: state IDLE, owner 0, mem_req 0, mem_we 0, all *_op_begun 0, all *_rdata_valid 0, *_rdata 0, starve_cnt 0, timeout counter 0, rd_timeout_err 0.
REQ-031 Reset mid-transaction abandons it; no ack or strobe is generated after release.

Configuration
REQ-032 Macro RAM_ARB_RR_EN defined: audio/video contention alternates strictly (round-robin, last-granted reader loses a tie); starve_cnt is absent.
REQ-033 Macro RAM_ARB_RR_EN undefined: fixed audio priority with the starvation guard of REQ-018/019.
REQ-034 The loader is highest priority in both builds.

Structure
REQ-035 Package ram_arb_pkg: state enum, owner encoding, default RD_TIMEOUT and STARVE_LIMIT constants.
REQ-036 Single module; no sub-module (selection logic is small and lives in the next-state comb block).

Verification
REQ-037 init_done=0, ld_we=1 at 0x000010/0xBEEF, a_req=1 -> loader granted; mem_we=1, mem_address=0x000010, mem_wdata=0xBEEF; a_op_begun stays 0.
REQ-038 init_done=1, a_req and v_req held, controller acks every 3 cycles -> (RR_EN undefined) 4 audio grants then 1 video grant, repeating; (RR_EN defined) A,V,A,V.
REQ-039 Video read at 0x1ABCDE; rdata_valid with 0x1234 two cycles after ack -> v_rdata_valid pulses 1 cycle, v_rdata=0x1234, a_rdata unchanged.
REQ-040 Audio read acked, no rdata_valid -> after 255 WAIT_RD cycles rd_timeout_err=1, state IDLE, next request served normally.
REQ-041 reset_n pulsed low during WAIT_RD -> all outputs 0 immediately; a later mem_rdata_valid produces no strobe.
REQ-042 a_req deasserted one cycle into GRANT_A before ack -> mem_req stays 1 until mem_op_begun; a_op_begun then pulses.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM states, owner codes
// and default timing constants.
package ram_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRANT_LD = 3'd1,
        S_GRANT_A  = 3'd2,
        S_GRANT_V  = 3'd3,
        S_WAIT_RD  = 3'd4
    } state_t;

    // Encoding of the owner output (who currently holds the memory port)
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_LD   = 2'd1;
    localparam logic [1:0] OWN_A    = 2'd2;
    localparam logic [1:0] OWN_V    = 2'd3;

    // Default timing constants
    localparam int DEF_RD_TIMEOUT   = 255;
    localparam int DEF_STARVE_LIMIT = 4;

    // Saturating 3-bit increment used by the video starvation counter
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Three-port SDRAM arbiter: loader (write), audio and video (read).
// The loader always wins; audio beats video unless video has been starved.
// Build option RAM_ARB_RR_EN: audio/video contention alternates strictly
// (round-robin) and the starvation counter is removed.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int RD_TIMEOUT   = DEF_RD_TIMEOUT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        init_done,
    // loader write port
    input  logic        ld_we,
    input  logic [24:0] ld_address,
    input  logic [15:0] ld_data,
    output logic        ld_op_begun,
    // audio read port
    input  logic        a_req,
    input  logic [24:0] a_address,
    output logic        a_op_begun,
    output logic        a_rdata_valid,
    output logic [15:0] a_rdata,
    // video read port
    input  logic        v_req,
    input  logic [24:0] v_address,
    output logic        v_op_begun,
    output logic        v_rdata_valid,
    output logic [15:0] v_rdata,
    // SDRAM controller side
    output logic        mem_req,
    output logic        mem_we,
    output logic [24:0] mem_address,
    output logic [15:0] mem_wdata,
    input  logic        mem_op_begun,
    input  logic        mem_rdata_valid,
    input  logic [15:0] mem_rdata,
    // status
    output logic [1:0]  owner,
    output logic        rd_timeout_err
);

    // Counter only needs to reach RD_TIMEOUT-1
    localparam int TMO_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT);

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               err_q, err_d;
    logic [15:0]        a_rdata_q, a_rdata_d;
    logic [15:0]        v_rdata_q, v_rdata_d;
`ifdef RAM_ARB_RR_EN
    logic               rr_last_a_q, rr_last_a_d;   // 1: audio won the last reader grant
`else
    logic [2:0]         starve_cnt_q, starve_cnt_d;
`endif

    // Reader requests only count once the loader has finished
    logic a_live, v_live;
    assign a_live = init_done & a_req;
    assign v_live = init_done & v_req;

    assign owner          = owner_q;
    assign rd_timeout_err = err_q;

    // State and data registers, cleared asynchronously
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_NONE;
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
            a_rdata_q    <= '0;
            v_rdata_q    <= '0;
`ifdef RAM_ARB_RR_EN
            rr_last_a_q  <= 1'b0;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            tmo_cnt_q    <= tmo_cnt_d;
            err_q        <= err_d;
            a_rdata_q    <= a_rdata_d;
            v_rdata_q    <= v_rdata_d;
`ifdef RAM_ARB_RR_EN
            rr_last_a_q  <= rr_last_a_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    // Arbitration, next-state logic and memory/port output muxing
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        tmo_cnt_d     = tmo_cnt_q;
        err_d         = err_q;
        a_rdata_d     = a_rdata_q;
        v_rdata_d     = v_rdata_q;
`ifdef RAM_ARB_RR_EN
        rr_last_a_d   = rr_last_a_q;
`else
        starve_cnt_d  = starve_cnt_q;
`endif
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_address   = '0;
        mem_wdata     = '0;
        ld_op_begun   = 1'b0;
        a_op_begun    = 1'b0;
        v_op_begun    = 1'b0;
        a_rdata_valid = 1'b0;
        v_rdata_valid = 1'b0;
        a_rdata       = a_rdata_q;
        v_rdata       = v_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (ld_we) begin
                    state_d = S_GRANT_LD;
                    owner_d = OWN_LD;
                end else if (a_live && v_live) begin
`ifdef RAM_ARB_RR_EN
                    // Tie: whoever was granted last loses
                    if (rr_last_a_q) begin
                        state_d     = S_GRANT_V;
                        owner_d     = OWN_V;
                        rr_last_a_d = 1'b0;
                    end else begin
                        state_d     = S_GRANT_A;
                        owner_d     = OWN_A;
                        rr_last_a_d = 1'b1;
                    end
`else
                    // Tie: audio wins unless video has lost too often
                    if (int'(starve_cnt_q) >= STARVE_LIMIT) begin
                        state_d      = S_GRANT_V;
                        owner_d      = OWN_V;
                        starve_cnt_d = '0;
                    end else begin
                        state_d      = S_GRANT_A;
                        owner_d      = OWN_A;
                        starve_cnt_d = sat_inc3(starve_cnt_q);
                    end
`endif
                end else if (a_live) begin
                    state_d = S_GRANT_A;
                    owner_d = OWN_A;
`ifdef RAM_ARB_RR_EN
                    rr_last_a_d = 1'b1;
`endif
                end else if (v_live) begin
                    state_d = S_GRANT_V;
                    owner_d = OWN_V;
`ifdef RAM_ARB_RR_EN
                    rr_last_a_d = 1'b0;
`else
                    starve_cnt_d = '0;
`endif
                end
            end

            S_GRANT_LD: begin
                mem_req     = 1'b1;
                mem_we      = 1'b1;
                mem_address = ld_address;
                mem_wdata   = ld_data;
                ld_op_begun = mem_op_begun;
                if (mem_op_begun) begin
                    state_d = S_IDLE;
                    owner_d = OWN_NONE;
                end
            end

            S_GRANT_A: begin
                mem_req     = 1'b1;
                mem_address = a_address;
                a_op_begun  = mem_op_begun;
                if (mem_op_begun) begin
                    state_d   = S_WAIT_RD;
                    tmo_cnt_d = '0;
                end
            end

            S_GRANT_V: begin
                mem_req     = 1'b1;
                mem_address = v_address;
                v_op_begun  = mem_op_begun;
                if (mem_op_begun) begin
                    state_d   = S_WAIT_RD;
                    tmo_cnt_d = '0;
                end
            end

            S_WAIT_RD: begin
                // owner_q still names the reader whose data is pending
                if (mem_rdata_valid) begin
                    if (owner_q == OWN_V) begin
                        v_rdata_valid = 1'b1;
                        v_rdata       = mem_rdata;
                        v_rdata_d     = mem_rdata;
                    end else begin
                        a_rdata_valid = 1'b1;
                        a_rdata       = mem_rdata;
                        a_rdata_d     = mem_rdata;
                    end
                    state_d   = S_IDLE;
                    owner_d   = OWN_NONE;
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TMO_W'(RD_TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                    owner_d   = OWN_NONE;
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: arbitration table, hand-written
// multi-cycle sequences and a randomized run against a transaction model.
`timescale 1ns/1ps
module tb_ram_arbiter;

    logic        clk50 = 1'b0;
    logic        reset_n;
    logic        init_done;
    logic        ld_we;
    logic [24:0] ld_address;
    logic [15:0] ld_data;
    logic        ld_op_begun;
    logic        a_req;
    logic [24:0] a_address;
    logic        a_op_begun;
    logic        a_rdata_valid;
    logic [15:0] a_rdata;
    logic        v_req;
    logic [24:0] v_address;
    logic        v_op_begun;
    logic        v_rdata_valid;
    logic [15:0] v_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_op_begun;
    logic        mem_rdata_valid;
    logic [15:0] mem_rdata;
    logic [1:0]  owner;
    logic        rd_timeout_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk50 = ~clk50;

    ram_arbiter dut (
        .clk50          (clk50),
        .reset_n        (reset_n),
        .init_done      (init_done),
        .ld_we          (ld_we),
        .ld_address     (ld_address),
        .ld_data        (ld_data),
        .ld_op_begun    (ld_op_begun),
        .a_req          (a_req),
        .a_address      (a_address),
        .a_op_begun     (a_op_begun),
        .a_rdata_valid  (a_rdata_valid),
        .a_rdata        (a_rdata),
        .v_req          (v_req),
        .v_address      (v_address),
        .v_op_begun     (v_op_begun),
        .v_rdata_valid  (v_rdata_valid),
        .v_rdata        (v_rdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_op_begun   (mem_op_begun),
        .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata      (mem_rdata),
        .owner          (owner),
        .rd_timeout_err (rd_timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    task automatic clear_inputs();
        init_done       = 1'b0;
        ld_we           = 1'b0;
        a_req           = 1'b0;
        v_req           = 1'b0;
        mem_op_begun    = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_rdata       = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    function automatic logic [24:0] addr_of(input int who);
        case (who)
            1:       return ld_address;
            2:       return a_address;
            3:       return v_address;
            default: return 25'd0;
        endcase
    endfunction

    // Wait (bounded) for a reader grant and report which reader holds it
    task automatic wait_grant(output int who);
        who = 0;
        for (int k = 0; k < 8; k++) begin
            if (owner == 2'd2 || owner == 2'd3) begin
                who = int'(owner);
                return;
            end
            step();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL grant_wait: owner=%0d after 8 cycles, required a reader grant", owner);
    endtask

    typedef struct {
        logic init;
        logic ld;
        logic a;
        logic v;
        int   exp_own;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int who;
        int exp_who;
        logic [15:0] dat;
        // reference model state for the randomized run
        int   m_starve;
        logic m_last_a;
        logic [15:0] m_a_rdata;
        logic [15:0] m_v_rdata;

        ld_address = 25'h000010;
        ld_data    = 16'hBEEF;
        a_address  = 25'h0AAAAA;
        v_address  = 25'h1ABCDE;
        do_reset();

        // ---------------- reset state ----------------
        check("rst_owner",   owner, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we",  mem_we, 0);
        check("rst_err",     rd_timeout_err, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_v_rdata", v_rdata, 0);

        // ---------------- arbitration table ----------------
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1};   // loader before init, audio blocked
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 0};   // readers blocked before init
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 3};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 2};   // audio over video, no starvation yet
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1};   // loader always wins
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 0};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            init_done = vecs[i].init;
            ld_we     = vecs[i].ld;
            a_req     = vecs[i].a;
            v_req     = vecs[i].v;
            step();
            check("vec_owner",   owner, vecs[i].exp_own);
            check("vec_mem_req", mem_req, vecs[i].exp_own != 0);
            check("vec_mem_we",  mem_we, vecs[i].exp_own == 1);
            if (vecs[i].exp_own != 0) begin
                check("vec_addr",  mem_address, addr_of(vecs[i].exp_own));
                check("vec_wdata", mem_wdata, (vecs[i].exp_own == 1) ? 16'hBEEF : 16'h0000);
                mem_op_begun = 1'b1;
                #1;
                check("vec_acks", {ld_op_begun, a_op_begun, v_op_begun},
                      {vecs[i].exp_own == 1, vecs[i].exp_own == 2, vecs[i].exp_own == 3});
                step();
                mem_op_begun = 1'b0;
                ld_we = 1'b0; a_req = 1'b0; v_req = 1'b0;
                if (vecs[i].exp_own != 1) begin
                    mem_rdata_valid = 1'b1;
                    mem_rdata       = 16'h0F00 + 16'(i);
                    #1;
                    check("vec_rvalid", {a_rdata_valid, v_rdata_valid},
                          {vecs[i].exp_own == 2, vecs[i].exp_own == 3});
                    step();
                    mem_rdata_valid = 1'b0;
                end
            end
            $display("vec %0d: init=%0d ld=%0d a=%0d v=%0d owner=%0d", i,
                     vecs[i].init, vecs[i].ld, vecs[i].a, vecs[i].v, vecs[i].exp_own);
        end

        // ---------------- contention order, acks every 3 cycles ----------------
        do_reset();
        init_done = 1'b1; a_req = 1'b1; v_req = 1'b1;
        for (int g = 0; g < 10; g++) begin
            wait_grant(who);
`ifdef RAM_ARB_RR_EN
            exp_who = (g % 2 == 1) ? 3 : 2;
`else
            exp_who = (g % 5 == 4) ? 3 : 2;
`endif
            check("order_grant", who, exp_who);
            step();
            step();
            mem_op_begun = 1'b1;
            step();
            mem_op_begun = 1'b0;
            mem_rdata_valid = 1'b1;
            mem_rdata = 16'(g);
            step();
            mem_rdata_valid = 1'b0;
            $display("order %0d: reader=%0d", g, who);
        end

        // ---------------- grant held after request drops ----------------
        do_reset();
        init_done = 1'b1; a_req = 1'b1; a_address = 25'h0000AA;
        step();
        check("hold_owner", owner, 2);
        a_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_mem_req", mem_req, 1);
            check("hold_no_ack", a_op_begun, 0);
        end
        a_address = 25'h00BBBB;
        #1;
        check("hold_live_addr", mem_address, 25'h00BBBB);
        mem_op_begun = 1'b1;
        #1;
        check("hold_a_ack", a_op_begun, 1);
        step();
        mem_op_begun = 1'b0;
        check("wait_mem_req", mem_req, 0);
        check("wait_owner", owner, 2);
        mem_rdata_valid = 1'b1; mem_rdata = 16'h5555;
        #1;
        check("a_rvalid", a_rdata_valid, 1);
        check("a_rdata", a_rdata, 16'h5555);
        step();
        mem_rdata_valid = 1'b0;
        check("a_rvalid_pulse", a_rdata_valid, 0);
        check("a_rdata_hold", a_rdata, 16'h5555);
        check("a_done_owner", owner, 0);
        $display("seq hold: audio read 0x5555 done");

        // ---------------- video read ----------------
        v_req = 1'b1; v_address = 25'h1ABCDE;
        step();
        check("v_owner", owner, 3);
        check("v_addr", mem_address, 25'h1ABCDE);
        mem_op_begun = 1'b1;
        #1;
        check("v_acks", {ld_op_begun, a_op_begun, v_op_begun}, 3'b001);
        step();
        mem_op_begun = 1'b0; v_req = 1'b0;
        check("v_early_valid", v_rdata_valid, 0);
        step();
        mem_rdata_valid = 1'b1; mem_rdata = 16'h1234;
        #1;
        check("v_rvalid", v_rdata_valid, 1);
        check("v_rdata", v_rdata, 16'h1234);
        check("v_a_untouched", a_rdata, 16'h5555);
        check("v_no_a_valid", a_rdata_valid, 0);
        step();
        mem_rdata_valid = 1'b0;
        check("v_rvalid_pulse", v_rdata_valid, 0);
        check("v_rdata_hold", v_rdata, 16'h1234);
        // stray strobe while idle must be ignored
        mem_rdata_valid = 1'b1; mem_rdata = 16'hDEAD;
        #1;
        check("idle_strobe", {a_rdata_valid, v_rdata_valid}, 2'b00);
        step();
        mem_rdata_valid = 1'b0;
        check("idle_v_rdata", v_rdata, 16'h1234);
        $display("seq video: read 0x1234 done");

        // ---------------- read timeout ----------------
        a_req = 1'b1;
        step();
        mem_op_begun = 1'b1;
        step();
        mem_op_begun = 1'b0; a_req = 1'b0;
        repeat (254) step();
        check("tmo_still_waiting", owner, 2);
        check("tmo_err_early", rd_timeout_err, 0);
        step();
        check("tmo_owner_idle", owner, 0);
        check("tmo_err_set", rd_timeout_err, 1);
        check("tmo_no_strobe", a_rdata_valid, 0);
        mem_rdata_valid = 1'b1; mem_rdata = 16'hAAAA;
        #1;
        check("tmo_late_strobe", a_rdata_valid, 0);
        step();
        mem_rdata_valid = 1'b0;
        v_req = 1'b1;
        step();
        check("tmo_next_owner", owner, 3);
        mem_op_begun = 1'b1;
        step();
        mem_op_begun = 1'b0; v_req = 1'b0;
        mem_rdata_valid = 1'b1; mem_rdata = 16'h7777;
        #1;
        check("tmo_next_rdata", v_rdata, 16'h7777);
        step();
        mem_rdata_valid = 1'b0;
        check("tmo_err_sticky", rd_timeout_err, 1);
        $display("seq timeout: error flagged, next read served");

        // ---------------- reset during WAIT_RD ----------------
        a_req = 1'b1;
        step();
        mem_op_begun = 1'b1;
        step();
        mem_op_begun = 1'b0; a_req = 1'b0;
        #2;
        reset_n = 1'b0;
        mem_rdata_valid = 1'b1; mem_rdata = 16'h9999;
        #1;
        check("arst_owner", owner, 0);
        check("arst_mem_req", mem_req, 0);
        check("arst_a_rdata", a_rdata, 0);
        check("arst_v_rdata", v_rdata, 0);
        check("arst_err", rd_timeout_err, 0);
        check("arst_valid", {a_rdata_valid, v_rdata_valid}, 2'b00);
        step();
        reset_n = 1'b1;
        #1;
        check("arst_post_strobe", {a_rdata_valid, v_rdata_valid}, 2'b00);
        step();
        check("arst_post_owner", owner, 0);
        check("arst_post_strobe2", a_rdata_valid, 0);
        mem_rdata_valid = 1'b0;
        $display("seq reset: transaction abandoned");

        // ---------------- randomized run against transaction model ----------------
        do_reset();
        m_starve  = 0;
        m_last_a  = 1'b0;
        m_a_rdata = '0;
        m_v_rdata = '0;
        for (int r = 0; r < 150; r++) begin
            int   win;
            logic ra, rv;
            init_done  = ($urandom_range(0, 3) != 0);
            ld_we      = ($urandom_range(0, 4) == 0);
            a_req      = 1'($urandom_range(0, 1));
            v_req      = 1'($urandom_range(0, 1));
            ld_address = 25'($urandom);
            ld_data    = 16'($urandom);
            a_address  = 25'($urandom);
            v_address  = 25'($urandom);

            ra  = init_done && a_req;
            rv  = init_done && v_req;
            win = 0;
            if (ld_we)            win = 1;
            else if (ra && rv) begin
`ifdef RAM_ARB_RR_EN
                win = m_last_a ? 3 : 2;
`else
                win = (m_starve >= 4) ? 3 : 2;
`endif
            end
            else if (ra)          win = 2;
            else if (rv)          win = 3;
`ifdef RAM_ARB_RR_EN
            if (win == 2) m_last_a = 1'b1;
            if (win == 3) m_last_a = 1'b0;
`else
            if (win == 2 && rv) m_starve = (m_starve >= 7) ? 7 : m_starve + 1;
            if (win == 3)       m_starve = 0;
`endif

            step();
            check("rnd_owner", owner, win);
            check("rnd_mem_we", mem_we, win == 1);
            if (win != 0) begin
                check("rnd_addr", mem_address, addr_of(win));
                repeat ($urandom_range(0, 3)) begin
                    a_req     = 1'($urandom_range(0, 1));
                    v_req     = 1'($urandom_range(0, 1));
                    init_done = 1'($urandom_range(0, 1));
                    step();
                    check("rnd_hold", {owner, mem_req}, {2'(win), 1'b1});
                end
                mem_op_begun = 1'b1;
                #1;
                check("rnd_acks", {ld_op_begun, a_op_begun, v_op_begun},
                      {win == 1, win == 2, win == 3});
                step();
                mem_op_begun = 1'b0;
                ld_we = 1'b0; a_req = 1'b0; v_req = 1'b0;
                if (win != 1) begin
                    repeat ($urandom_range(0, 4)) step();
                    dat = 16'($urandom);
                    if (win == 2) m_a_rdata = dat;
                    else          m_v_rdata = dat;
                    mem_rdata_valid = 1'b1;
                    mem_rdata       = dat;
                    #1;
                    check("rnd_rvalid", {a_rdata_valid, v_rdata_valid}, {win == 2, win == 3});
                    check("rnd_rdata", {a_rdata, v_rdata}, {m_a_rdata, m_v_rdata});
                    step();
                    mem_rdata_valid = 1'b0;
                end
            end else begin
                ld_we = 1'b0; a_req = 1'b0; v_req = 1'b0;
            end
            $display("rnd %0d: init=%0d winner=%0d", r, init_done, win);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
